// File: rtl/wbledwalker.sv
// Wishbone-controlled walking LED: one-hot LED steps up (and optionally back down)
// with a programmable hold period, repeat count, abort, and done status.
module wbledwalker #(
  parameter int unsigned NLEDS          = 8,
  parameter logic [31:0] DEFAULT_PERIOD = 32'd0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cyc,
  input  logic             i_stb,
  input  logic             i_we,
  input  logic [1:0]       i_addr,
  input  logic [31:0]      i_data,
  output logic             o_stall,
  output logic             o_ack,
  output logic [31:0]      o_data,
  output logic [NLEDS-1:0] o_led
);

  localparam logic [4:0] LAST_POS = 5'(NLEDS - 1);
  localparam logic [4:0] TURN_POS = 5'(NLEDS - 2);

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DOWN
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       pos_q, pos_d;
  logic [31:0]      timer_q, timer_d;
  logic [7:0]       passes_q, passes_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic [31:0]      period_q, period_d;
  logic [NLEDS-1:0] led_q, led_d;
  logic             ack_q, ack_d;
  logic [31:0]      rdata_q, rdata_d;

  logic busy;
  logic accept;
  logic pass_end;

  assign busy    = (state_q != IDLE);
  assign o_stall = busy && i_we && (i_addr == 2'd0);
  assign accept  = i_cyc && i_stb && !o_stall;

  assign o_ack  = ack_q;
  assign o_data = rdata_q;
  assign o_led  = led_q;

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    timer_d  = timer_q;
    passes_d = passes_q;
    mode_d   = mode_q;
    done_d   = done_q;
    period_d = period_q;
    ack_d    = accept;
    rdata_d  = '0;
    pass_end = 1'b0;
    led_d    = '0;

    if (state_q != IDLE) begin
      if (timer_q != 32'd0) begin
        timer_d = timer_q - 32'd1;
      end else begin
        timer_d = period_q;
        case (state_q)
          UP: begin
            if (pos_q == LAST_POS) begin
              if (mode_q) begin
                state_d = DOWN;
                pos_d   = TURN_POS;
              end else begin
                pass_end = 1'b1;
              end
            end else begin
              pos_d = pos_q + 5'd1;
            end
          end
          DOWN: begin
            if (pos_q == 5'd0) begin
              pass_end = 1'b1;
            end else begin
              pos_d = pos_q - 5'd1;
            end
          end
          default: ;
        endcase

        if (pass_end) begin
          if (passes_q != 8'd0) begin
            passes_d = passes_q - 8'd1;
            state_d  = UP;
            pos_d    = 5'd0;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
    end

    // Bus requests are applied after the walk step so an abort overrides a
    // natural completion landing on the same edge.
    if (accept) begin
      if (i_we) begin
        case (i_addr)
          2'd0: begin
            state_d  = UP;
            pos_d    = 5'd0;
            timer_d  = period_q;
            passes_d = i_data[15:8];
            mode_d   = i_data[16];
            done_d   = 1'b0;
          end
          2'd1: period_d = i_data;
          2'd2: begin
            state_d = IDLE;
            done_d  = 1'b0;
          end
          default: ;
        endcase
      end else begin
        case (i_addr)
          2'd0:    rdata_d = {busy, 14'b0, mode_q, passes_q, 3'b0, pos_q};
          2'd1:    rdata_d = period_q;
          2'd2:    rdata_d = {31'b0, done_q};
          default: rdata_d = '0;
        endcase
      end
    end

    for (int unsigned i = 0; i < NLEDS; i++) begin
      led_d[i] = (state_d != IDLE) && (pos_d == 5'(i));
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      pos_q    <= '0;
      timer_q  <= '0;
      passes_q <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
      period_q <= DEFAULT_PERIOD;
      led_q    <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      timer_q  <= timer_d;
      passes_q <= passes_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
      period_q <= period_d;
      led_q    <= led_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_wbledwalker.sv
// Self-checking bench for wbledwalker: register vector table, directed corner
// sequences, and random traffic against a position-list reference model.
module tb_wbledwalker;

  localparam int unsigned N   = 8;
  localparam logic [31:0] DEF = 32'd4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cyc, stb, we;
  logic [1:0]    addr;
  logic [31:0]   data;
  logic          o_stall, o_ack;
  logic [31:0]   o_data;
  logic [N-1:0]  o_led;

  wbledwalker #(.NLEDS(N), .DEFAULT_PERIOD(DEF)) dut (
    .i_clk(clk), .i_reset(rst), .i_cyc(cyc), .i_stb(stb), .i_we(we),
    .i_addr(addr), .i_data(data), .o_stall(o_stall), .o_ack(o_ack),
    .o_data(o_data), .o_led(o_led)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a walk is the flat list of (position, passes-left) it visits.
  typedef struct {
    int unsigned pos;
    int unsigned prem;
  } step_t;

  step_t       mq[$];
  logic        m_busy, m_done, m_mode, m_acc, m_stall;
  logic [31:0] m_period, m_cnt, exp_data;
  int unsigned m_pos, m_prem;
  logic        exp_ack;
  logic [N-1:0] exp_led;
  logic        last_stall;

  task automatic model_reset();
    mq.delete();
    m_busy = 0; m_done = 0; m_mode = 0; m_acc = 0;
    m_period = DEF; m_cnt = 0; m_pos = 0; m_prem = 0;
    exp_ack = 0; exp_data = 0; exp_led = '0;
  endtask

  task automatic build(input logic mode, input int unsigned rep);
    mq.delete();
    for (int p = int'(rep); p >= 0; p--) begin
      for (int i = 0; i < int'(N); i++) mq.push_back('{pos: i, prem: p});
      if (mode) for (int i = int'(N) - 2; i >= 0; i--) mq.push_back('{pos: i, prem: p});
    end
  endtask

  task automatic m_step();
    logic        pre_busy;
    logic [31:0] old_period, rd;
    step_t       s;
    pre_busy   = m_busy;
    old_period = m_period;
    m_stall    = m_busy && we && (addr == 2'd0);
    m_acc      = cyc && stb && !m_stall;
    case (addr)
      2'd0:    rd = {m_busy, 14'b0, m_mode, 8'(m_prem), 3'b0, 5'(m_pos)};
      2'd1:    rd = m_period;
      2'd2:    rd = {31'b0, m_done};
      default: rd = 0;
    endcase
    if (m_busy) begin
      if (m_cnt == 0) begin
        s = mq.pop_front();
        if (mq.size() == 0) begin
          m_busy = 0; m_done = 1; m_pos = s.pos; m_prem = s.prem;
        end else begin
          m_cnt = old_period;
        end
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
    if (m_busy) begin
      m_pos = mq[0].pos; m_prem = mq[0].prem;
    end
    if (m_acc && we) begin
      case (addr)
        2'd0: begin
          build(data[16], int'(data[15:8]));
          m_mode = data[16]; m_busy = 1; m_done = 0; m_cnt = old_period;
          m_pos = 0; m_prem = data[15:8];
        end
        2'd1: m_period = data;
        2'd2: begin
          m_busy = 0; m_done = 0; mq.delete();
        end
        default: ;
      endcase
    end
    if (pre_busy && !m_busy && mq.size() != 0) mq.delete();
    exp_ack  = m_acc;
    exp_data = (m_acc && !we) ? rd : 32'd0;
    exp_led  = '0;
    if (m_busy) exp_led[m_pos] = 1'b1;
  endtask

  task automatic tick();
    #1;
    last_stall = o_stall;
    chk("stall", 32'(o_stall), 32'(m_busy && we && (addr == 2'd0)));
    @(posedge clk);
    m_step();
    #1;
    chk("led", 32'(o_led), 32'(exp_led));
    chk("ack", 32'(o_ack), 32'(exp_ack));
    if (exp_ack) chk("rdata", o_data, exp_data);
    chk("led_onehot0", 32'($onehot0(o_led)), 32'd1);
  endtask

  task automatic idle();
    cyc = 0; stb = 0; we = 0; addr = 0; data = 0;
  endtask

  task automatic req(input logic w, input logic [1:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output int unsigned waits);
    logic got;
    got = 0; waits = 0; rd = '0;
    cyc = 1; stb = 1; we = w; addr = a; data = d;
    for (int t = 0; t < 2000; t++) begin
      tick();
      if (m_acc) begin
        got = 1;
        rd  = o_data;
        break;
      end
      waits++;
    end
    if (!got) chk("req_timeout", 32'd0, 32'd1);
    idle();
  endtask

  typedef struct {
    logic        cyc, stb, we;
    logic [1:0]  addr;
    logic [31:0] data;
    logic        ack;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int unsigned waits, cnt;
    int unsigned r;

    vt[0] = '{1, 1, 1, 2'd1, 32'h0000_0007, 1, 32'h0};
    vt[1] = '{1, 1, 0, 2'd1, 32'h0,         1, 32'h0000_0007};
    vt[2] = '{1, 1, 1, 2'd3, 32'hDEAD_BEEF, 1, 32'h0};
    vt[3] = '{1, 1, 0, 2'd3, 32'h0,         1, 32'h0};
    vt[4] = '{0, 1, 0, 2'd1, 32'h0,         0, 32'h0};
    vt[5] = '{1, 1, 0, 2'd2, 32'h0,         1, 32'h0};
    vt[6] = '{1, 1, 0, 2'd0, 32'h0,         1, 32'h0};
    vt[7] = '{1, 1, 1, 2'd2, 32'h1234_5678, 1, 32'h0};
    vt[8] = '{1, 1, 0, 2'd1, 32'h0,         1, 32'h0000_0007};

    idle();
    model_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_led", 32'(o_led), 32'd0);
    chk("reset_ack", 32'(o_ack), 32'd0);
    chk("reset_data", o_data, 32'd0);
    chk("reset_stall", 32'(o_stall), 32'd0);
    rst = 0;

    req(0, 2'd1, 0, rd, waits);
    chk("reset_period", rd, DEF);

    for (int i = 0; i < 9; i++) begin
      cyc = vt[i].cyc; stb = vt[i].stb; we = vt[i].we;
      addr = vt[i].addr; data = vt[i].data;
      tick();
      chk("vec_ack", 32'(o_ack), 32'(vt[i].ack));
      if (vt[i].ack && !vt[i].we) chk("vec_rdata", o_data, vt[i].rdata);
    end
    idle();

    // One-way walk, zero period: one LED per clock, eight busy cycles.
    req(1, 2'd1, 32'd0, rd, waits);
    req(1, 2'd0, 32'd0, rd, waits);
    for (int i = 0; i < int'(N); i++) begin
      chk("oneway_led", 32'(o_led), 32'd1 << i);
      tick();
    end
    chk("oneway_end_led", 32'(o_led), 32'd0);
    req(0, 2'd2, 0, rd, waits);
    chk("oneway_done", rd, 32'd1);

    // Bounce, period 2, one repeat: 2 passes x 15 positions x 3 clocks.
    req(1, 2'd1, 32'd2, rd, waits);
    req(1, 2'd0, 32'h0001_0100, rd, waits);
    cnt = 0;
    for (int t = 0; t < 400; t++) begin
      if (o_led == '0) break;
      cnt++;
      tick();
    end
    chk("bounce_busy_clocks", cnt, 32'd90);
    req(0, 2'd2, 0, rd, waits);
    chk("bounce_done", rd, 32'd1);

    // Start while busy stalls until the walk ends; reads never stall.
    req(1, 2'd1, 32'd1, rd, waits);
    req(1, 2'd0, 32'd0, rd, waits);
    tick();
    tick();
    req(0, 2'd0, 0, rd, waits);
    chk("busy_read_waits", waits, 32'd0);
    chk("busy_read_busy", 32'(rd[31]), 32'd1);
    chk("busy_read_pos", 32'(rd[4:0]), 32'd1);
    req(1, 2'd0, 32'd0, rd, waits);
    chk("stalled_start_waits", waits, 32'd13);
    chk("restart_led", 32'(o_led), 32'd1);
    req(1, 2'd2, 32'd0, rd, waits);

    // Abort at position 5.
    req(1, 2'd1, 32'd0, rd, waits);
    req(1, 2'd0, 32'd0, rd, waits);
    repeat (5) tick();
    chk("abort_pre_led", 32'(o_led), 32'h20);
    req(1, 2'd2, 32'hFFFF_FFFF, rd, waits);
    chk("abort_led", 32'(o_led), 32'd0);
    req(0, 2'd2, 0, rd, waits);
    chk("abort_done", rd, 32'd0);
    req(0, 2'd0, 0, rd, waits);
    chk("abort_busy", 32'(rd[31]), 32'd0);

    // Maximum period holds the first LED without wrapping.
    req(1, 2'd1, 32'hFFFF_FFFF, rd, waits);
    req(1, 2'd0, 32'd0, rd, waits);
    repeat (40) tick();
    chk("maxperiod_led", 32'(o_led), 32'd1);
    req(1, 2'd2, 32'd0, rd, waits);

    // Asynchronous reset mid-walk with an acknowledge outstanding.
    req(1, 2'd1, 32'd0, rd, waits);
    req(1, 2'd0, 32'd0, rd, waits);
    repeat (3) tick();
    chk("reset_pre_led", 32'(o_led), 32'h08);
    cyc = 1; stb = 1; we = 0; addr = 2'd1;
    tick();
    chk("reset_pre_ack", 32'(o_ack), 32'd1);
    #2;
    rst = 1;
    #1;
    chk("async_reset_led", 32'(o_led), 32'd0);
    chk("async_reset_ack", 32'(o_ack), 32'd0);
    chk("async_reset_data", o_data, 32'd0);
    idle();
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    req(0, 2'd1, 0, rd, waits);
    chk("post_reset_period", rd, DEF);
    chk("post_reset_waits", waits, 32'd0);

    // Random traffic against the model.
    for (int t = 0; t < 1500; t++) begin
      idle();
      r = $urandom_range(0, 15);
      if (r >= 6 && r <= 8) begin
        cyc = 1; stb = 1; we = 0; addr = 2'($urandom_range(0, 3));
      end else if (r == 9 || r == 10) begin
        cyc = 1; stb = 1; we = 1; addr = 2'd0;
        data = {15'($urandom), 1'($urandom), 8'($urandom_range(0, 2)), 8'($urandom)};
      end else if (r == 11) begin
        cyc = 1; stb = 1; we = 1; addr = 2'd1; data = 32'($urandom_range(0, 3));
      end else if (r == 12 && $urandom_range(0, 7) == 0) begin
        cyc = 1; stb = 1; we = 1; addr = 2'd2; data = $urandom;
      end else if (r == 13) begin
        cyc = 0; stb = 1; we = 1'($urandom); addr = 2'($urandom); data = $urandom;
      end else if (r == 14) begin
        cyc = 1; stb = 1; we = 1; addr = 2'd3; data = $urandom;
      end
      tick();
    end
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
